// File: rtl/kw_fifo_push_arb_if.sv
// Push-port bundle between NUM_REQ producers, the push arbiter and the FIFO write side.
// The arbiter takes the master modport; the producer/FIFO side takes the slave modport.
interface kw_fifo_push_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          push_req;
    logic [DATA_WIDTH-1:0]         data_o;
    logic [IDX_WIDTH-1:0]          owner;
    logic                          locked;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, push_req, data_o, owner, locked
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, push_req, data_o, owner, locked
    );
endinterface

// File: rtl/kw_fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port between NUM_REQ producers.
// Define KW_FIFO_PUSH_ARB_BURST_EN to let an owner keep the port for up to MAX_BURST words.
module kw_fifo_push_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    kw_fifo_push_arb_if.master bus
);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_param_check
        $error("kw_fifo_push_arb: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                     input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_WIDTH'(sum);
    endfunction

    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic [IDX_WIDTH-1:0] owner_q;
    logic [IDX_WIDTH-1:0] winner;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 found;
    logic                 cont;
    logic                 grant_en;
    logic                 new_burst;
    logic                 locked_now;
    logic [NUM_REQ-1:0]   gnt_vec;
    logic [DATA_WIDTH-1:0] data_mux;

    // Cyclic search from rr_ptr: the lowest offset with a set request wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[wrap_add(rr_ptr_q, k)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign grant_en  = reset_n && !bus.fifo_full;
    assign new_burst = grant_en && !cont && found;
    assign grant_idx = cont ? owner_q : winner;

    always_comb begin
        gnt_vec = '0;
        if (grant_en && (cont || found)) gnt_vec[grant_idx] = 1'b1;
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) data_mux = data_mux | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.gnt      = gnt_vec;
    assign bus.push_req = |gnt_vec;
    assign bus.data_o   = data_mux;
    assign bus.owner    = owner_q;
    assign bus.locked   = locked_now;

    // Owner and pointer move only on a fresh search win; continued bursts leave them alone.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else if (new_burst) begin
            owner_q  <= winner;
            rr_ptr_q <= wrap_add(winner, 1);
        end
    end

`ifdef KW_FIFO_PUSH_ARB_BURST_EN
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

    assign locked_now = (state_q == LOCKED);
    assign cont       = locked_now && bus.req[owner_q] && (burst_cnt_q < CNT_WIDTH'(MAX_BURST));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= UNLOCKED;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // A stalled burst (fifo_full) keeps its count; only an owner drop ends it early.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (new_burst) begin
            burst_cnt_d = CNT_WIDTH'(1);
            state_d     = (MAX_BURST > 1) ? LOCKED : UNLOCKED;
        end else if (grant_en && cont) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (burst_cnt_d == CNT_WIDTH'(MAX_BURST)) state_d = UNLOCKED;
        end else if (locked_now && !bus.req[owner_q]) begin
            state_d = UNLOCKED;
        end
    end
`else
    assign locked_now = 1'b0;
    assign cont       = 1'b0;
`endif

endmodule

// File: tb/tb_kw_fifo_push_arb.sv
// Self-checking bench for kw_fifo_push_arb: directed sequences with literal expectations
// plus randomized traffic compared every cycle against a behavioural round-robin model.
module tb_kw_fifo_push_arb;
    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int MAX_BURST  = 4;
`ifdef KW_FIFO_PUSH_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    kw_fifo_push_arb_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    kw_fifo_push_arb #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, where the next search starts, words used.
    int m_rr;
    int m_owner;
    int m_cnt;
    bit m_locked;

    function automatic bit model_continues();
        return BURST_EN && m_locked && bus.req[m_owner] && (m_cnt < MAX_BURST);
    endfunction

    function automatic int model_grant();
        if (!reset_n || bus.fifo_full) return -1;
        if (model_continues()) return m_owner;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    initial begin
        m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    end

    always @(posedge clock) begin
        int g;
        bit c;
        c = model_continues();
        g = model_grant();
        if (!reset_n) begin
            m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
        end else if (g >= 0 && c) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MAX_BURST) m_locked = 1'b0;
        end else if (g >= 0) begin
            m_owner  = g;
            m_rr     = (g + 1) % NUM_REQ;
            m_cnt    = 1;
            m_locked = BURST_EN && (MAX_BURST > 1);
        end else if (m_locked && !bus.req[m_owner]) begin
            m_locked = 1'b0;
        end
    end

    always @(negedge clock) begin
        int g;
        logic [NUM_REQ-1:0]    eg;
        logic [DATA_WIDTH-1:0] ed;
        g  = model_grant();
        eg = '0;
        ed = '0;
        if (g >= 0) begin
            eg = NUM_REQ'(1 << g);
            ed = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
        check("model_gnt", 32'(bus.gnt), 32'(eg));
        check("model_push_req", 32'(bus.push_req), 32'(g >= 0));
        check("model_data_o", 32'(bus.data_o), 32'(ed));
        check("model_owner", 32'(bus.owner), 32'(m_owner));
        check("model_locked", 32'(bus.locked), 32'(m_locked));
    end

    // One cycle of directed stimulus with a hand-computed grant expectation.
    task automatic step(input string name, input logic [3:0] r, input bit full,
                        input bit rstn, input logic [3:0] exp);
        bus.req       = r;
        bus.fifo_full = full;
        reset_n       = rstn;
        bus.req_data  = {$urandom(), $urandom()};
        @(negedge clock);
        check(name, 32'(bus.gnt), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] exp_full_b [9];
        logic [3:0] exp_full_n [9];
        exp_full_b = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        exp_full_n = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
        checks = 0;
        errors = 0;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state and idle.
        step("reset_gnt", 4'b0101, 1'b0, 1'b0, 4'b0000);
        @(negedge clock);
        check("reset_owner", 32'(bus.owner), 32'd0);
        check("reset_locked", 32'(bus.locked), 32'd0);
        @(posedge clock);
        #1;
        step("idle_gnt", 4'b0000, 1'b0, 1'b1, 4'b0000);

        // Single burst alternation between producers 0 and 2.
        for (int k = 0; k < 9; k++) begin
            step("burst_0101", 4'b0101, 1'b0, 1'b1,
                 BURST_EN ? ((k < 4 || k >= 8) ? 4'b0001 : 4'b0100)
                          : ((k % 2 == 0) ? 4'b0001 : 4'b0100));
        end

        // Owner drop: re-arbitration in the same cycle, new burst restarts count at 1.
        step("drop_reset", 4'b0011, 1'b0, 1'b0, 4'b0000);
        step("drop_a", 4'b0011, 1'b0, 1'b1, 4'b0001);
        step("drop_b", 4'b0011, 1'b0, 1'b1, BURST_EN ? 4'b0001 : 4'b0010);
        step("drop_switch", 4'b0010, 1'b0, 1'b1, 4'b0010);
        step("drop_c", 4'b0011, 1'b0, 1'b1, BURST_EN ? 4'b0010 : 4'b0001);
        step("drop_d", 4'b0011, 1'b0, 1'b1, 4'b0010);
        step("drop_e", 4'b0011, 1'b0, 1'b1, BURST_EN ? 4'b0010 : 4'b0001);
        step("drop_f", 4'b0011, 1'b0, 1'b1, BURST_EN ? 4'b0001 : 4'b0010);

        // Full mid-burst: the burst pauses and resumes with its remaining words.
        step("full_reset", 4'b1100, 1'b0, 1'b0, 4'b0000);
        for (int k = 0; k < 9; k++) begin
            step("full_mid_burst", 4'b1100, (k >= 2 && k <= 4), 1'b1,
                 BURST_EN ? exp_full_b[k] : exp_full_n[k]);
        end

        // All requesting for 20 cycles.
        step("all_reset", 4'b1111, 1'b0, 1'b0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step("all_req", 4'b1111, 1'b0, 1'b1,
                 BURST_EN ? 4'(1 << ((k / 4) % 4)) : 4'(1 << (k % 4)));
        end

        // Reset mid-burst discards the lock and restarts the search at 0.
        step("rmb_reset", 4'b0010, 1'b0, 1'b0, 4'b0000);
        step("rmb_a", 4'b0010, 1'b0, 1'b1, 4'b0010);
        step("rmb_b", 4'b0010, 1'b0, 1'b1, 4'b0010);
        step("rmb_pulse", 4'b0010, 1'b0, 1'b0, 4'b0000);
        step("rmb_after", 4'b1010, 1'b0, 1'b1, 4'b0010);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 35) bus.req = 4'($urandom());
            bus.fifo_full = ($urandom_range(0, 99) < 20);
            reset_n       = ($urandom_range(0, 99) >= 1);
            bus.req_data  = {$urandom(), $urandom()};
            @(posedge clock);
            #1;
        end

        reset_n = 1'b1;
        bus.req = '0;
        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kw_fifo_push_arb.md
# kw_fifo_push_arb

Round-robin arbiter that shares the single push port of a FIFO controller between `NUM_REQ` producers. Each cycle it selects at most one requester, asserts that requester's grant and drives the FIFO's push request and write data. It never pushes while the FIFO reports full. A granted requester holds the port for a burst of up to `MAX_BURST` words before priority rotates. It sits directly in front of the FIFO push/data inputs; the FIFO's `full` flag feeds back into it.

## Interface
- `NUM_REQ`, 4: number of producers; ≥ 2.
- `DATA_WIDTH`, 16: word width in bits; must match the FIFO data width.
- `MAX_BURST`, 4: maximum consecutive words granted to one owner; ≥ 1.
- `IDX_WIDTH`, `$clog2(NUM_REQ)`: derived; do not override.
- `clock`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  reset; synchronous and active-low.
- `req`  in  NUM_REQ  per-producer request, bit i = producer i.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer words, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  NUM_REQ  one-hot-or-zero grant; word i transferred on every rising edge where `gnt[i]`=1.
- `fifo_full`  in  1  FIFO full flag.
- `push_req`  out  1  FIFO push request, = OR of `gnt`.
- `data_o`  out  DATA_WIDTH  FIFO write data, = granted slice of `req_data`; 0 when no grant.
- `owner`  out  IDX_WIDTH  index of current or last burst owner.
- `locked`  out  1  burst lock held.

## Operation
- State registers:
  - `rr_ptr` (IDX_WIDTH): first index searched when unlocked.
  - `locked` (1).
  - `owner` (IDX_WIDTH).
  - `burst_cnt` (`$clog2(MAX_BURST+1)` bits): words pushed in the current burst.
- Two states: UNLOCKED (`locked`=0) and LOCKED (`locked`=1).
- **Continue condition:** `locked` & `req[owner]` & (`burst_cnt` < `MAX_BURST`).
- **Grant decision (combinational), in priority order:**
  - If `reset_n`=0 or `fifo_full`=1: `gnt`=0.
  - Else if the continue condition holds: `gnt` = one-hot(`owner`).
  - Else: grant the first set `req` bit found searching cyclically from `rr_ptr` upward, wrapping at NUM_REQ−1 → 0.
  - If no `req` bit is set: `gnt`=0.
- **New burst** (grant via search to winner w):
  - `owner`←w, `rr_ptr`←(w+1) mod NUM_REQ, `burst_cnt`←1, `locked`←1.
  - If `MAX_BURST`=1, `locked`←0 instead.
- **Continued burst** (grant to owner): `burst_cnt`+1; when it reaches `MAX_BURST`, `locked`←0.
- **Lock release:** lock is released in any cycle where `req[owner]`=0, regardless of `fifo_full`.
  - When the owner drops or exhausts its burst, re-arbitration happens in that same cycle. There is no bubble.
  - The old owner has the lowest priority in that search, because `rr_ptr` = owner+1.
- **fifo_full=1:** no grant is issued.
  - `locked`, `owner`, `burst_cnt` and `rr_ptr` hold, except that lock is still released if the owner drops `req`.
  - Full does not end a burst.
- **Producer rule:** hold `req` and the data slice stable until the grant is sampled. `req` may be withdrawn at any time.
- **Reset:** values after any rising edge with `reset_n`=0 are `rr_ptr`=0, `locked`=0, `owner`=0, `burst_cnt`=0.
  - Reset mid-burst discards the lock.
  - `gnt`, `push_req` and `data_o` are 0 while `reset_n`=0.

## Timing
- The `req`/`fifo_full` → `gnt`/`push_req`/`data_o` paths are purely combinational, giving zero-cycle grant latency.
- Throughput: one word per cycle while any request is present and the FIFO is not full.
- Simultaneous owner-drop and `fifo_full`: lock is released, nothing is granted, and the next non-full cycle arbitrates from `rr_ptr`.
- The FIFO sees `push_req`=1 only when `fifo_full`=0, so the arbiter can never cause a push-overflow error.

## Configuration
- `KW_FIFO_PUSH_ARB_BURST_EN` defined: burst locking as described above.
- Not defined:
  - `locked` is tied to 0 and `burst_cnt` is removed.
  - `MAX_BURST` is ignored and every grant is a new search, giving pure per-word round-robin.
  - `owner` still reports the last winner.

## Test plan
All scenarios use defaults and the macro defined unless stated.
- **Reset and single burst:** reset, `req`=0000 → `gnt`=0000, `push_req`=0. Then `req`=0101 → `gnt`=0001 for 4 cycles, then 0100 for 4 cycles, then 0001 again.
- **Owner drop:** `req`=0011; requester 0 drops `req` after 2 grants → `gnt`=0010 in the very next cycle (no idle cycle), `burst_cnt`=1.
- **Full mid-burst:** after 2 words to requester 2, `fifo_full`=1 for 3 cycles → `gnt`=0, `push_req`=0, `burst_cnt` stays 2. On release, requester 2 receives exactly 2 more words, then rotation to requester 3.
- **All requesting:** `req`=1111 continuously for 20 cycles → grant order 0×4, 1×4, 2×4, 3×4, 0×4. `push_req` is high all 20 cycles; `data_o` matches the granted slice each cycle.
- **Reset mid-burst:** `reset_n`=0 for 1 cycle during requester 1's burst → `gnt`=0 that cycle. Afterwards, `req`=1010 → `gnt`=0010 (search restarts at 0).
- **Macro undefined:** `req`=1111 → `gnt` sequence 0001, 0010, 0100, 1000, 0001; `locked`=0 throughout.
